s2p_frame_ctrl: RTL and testbench

Frame-level controller for the serial-to-parallel path. It hunts the serial bit stream for the sync code (default 0x5A), then assembles a fixed number of payload bytes and hands each one downstream over a valid/ready handshake. It aborts the frame on overrun and returns to sync hunting after every frame. It sits between the serial input pin/bit strobe and the parallel consumer.

---
 rtl/s2p_frame_ctrl.sv | 152 +++++++++++++++
 tb/tb_s2p_frame_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/s2p_frame_ctrl.sv
// Serial-to-parallel frame controller: hunts the bit stream for a sync code,
// then assembles FRAME_BYTES payload bytes and offers each on a valid/ready port.
module s2p_frame_ctrl #(
  parameter logic [7:0] SYNC_WORD   = 8'h5A,
  parameter int         FRAME_BYTES = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       S_IN,
  input  logic       BIT_VALID,
  input  logic       P_READY,
  output logic [7:0] P_DATA,
  output logic       P_VALID,
  output logic       P_LAST,
  output logic       FRAME_START,
  output logic       OVERRUN,
  output logic       BUSY,
  output logic [7:0] FRAME_CNT
);

  typedef enum logic {HUNT, RECEIVE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(FRAME_BYTES - 1);

  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [3:0] fill_q, fill_d;
  logic [7:0] byte_sr_q, byte_sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] p_data_q, p_data_d;
  logic       p_valid_q, p_valid_d;
  logic       p_last_q, p_last_d;
  logic       start_q, start_d;
  logic       ovr_q, ovr_d;
  logic       busy_q, busy_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  logic [7:0] new_byte;
  logic       last_byte;

  assign new_byte  = {byte_sr_q[6:0], S_IN};
  assign last_byte = (byte_cnt_q == LAST_IDX);

  // NOTE: every *_d gets its hold value first so no path through this block
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_d      = fill_q;
    byte_sr_d   = byte_sr_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    p_data_d    = p_data_q;
    p_valid_d   = p_valid_q;
    p_last_d    = p_last_q;
    frame_cnt_d = frame_cnt_q;
    start_d     = 1'b0;
    ovr_d       = 1'b0;

    // The consumer drains the output register independently of bit arrival.
    if (p_valid_q && P_READY)
      p_valid_d = 1'b0;

    unique case (state_q)
      HUNT: begin
        if (BIT_VALID) begin
          sr_d = {sr_q[6:0], S_IN};
          if (fill_q != 4'd8)
            fill_d = fill_q + 4'd1;
          if (fill_q >= 4'd7 && sr_d == SYNC_WORD) begin
            state_d    = RECEIVE;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 8'd0;
            start_d    = 1'b1;
          end
        end
      end

      RECEIVE: begin
        if (BIT_VALID) begin
          byte_sr_d = new_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_cnt_d = byte_cnt_q + 8'd1;
            fill_d     = 4'd0;
            if (!p_valid_q || P_READY) begin
              p_data_d  = new_byte;
              p_valid_d = 1'b1;
              p_last_d  = last_byte;
              if (last_byte) begin
                state_d     = HUNT;
                frame_cnt_d = frame_cnt_q + 8'd1;
              end
            end else begin
              // Consumer stalled: keep the pending byte, drop the new one.
              ovr_d   = 1'b1;
              state_d = HUNT;
            end
          end
        end
      end

      default: state_d = HUNT;
    endcase

    busy_d = (state_d == RECEIVE);
  end

  // NOTE: registers take non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= HUNT;
      sr_q        <= 8'h00;
      fill_q      <= 4'd0;
      byte_sr_q   <= 8'h00;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 8'd0;
      p_data_q    <= 8'h00;
      p_valid_q   <= 1'b0;
      p_last_q    <= 1'b0;
      start_q     <= 1'b0;
      ovr_q       <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_q      <= fill_d;
      byte_sr_q   <= byte_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      p_data_q    <= p_data_d;
      p_valid_q   <= p_valid_d;
      p_last_q    <= p_last_d;
      start_q     <= start_d;
      ovr_q       <= ovr_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign P_DATA      = p_data_q;
  assign P_VALID     = p_valid_q;
  assign P_LAST      = p_last_q;
  assign FRAME_START = start_q;
  assign OVERRUN     = ovr_q;
  assign BUSY        = busy_q;
  assign FRAME_CNT   = frame_cnt_q;

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Self-checking bench for s2p_frame_ctrl: directed frames plus randomized
// traffic compared every cycle against a queue-based behavioural model.
module tb_s2p_frame_ctrl;

  localparam logic [7:0] SYNC = 8'h5A;
  localparam int         NB   = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       S_IN = 1'b0;
  logic       BIT_VALID = 1'b0;
  logic       P_READY = 1'b0;
  logic [7:0] P_DATA;
  logic       P_VALID;
  logic       P_LAST;
  logic       FRAME_START;
  logic       OVERRUN;
  logic       BUSY;
  logic [7:0] FRAME_CNT;

  s2p_frame_ctrl #(.SYNC_WORD(SYNC), .FRAME_BYTES(NB)) dut (
    .CLK(CLK), .RESET(RESET), .S_IN(S_IN), .BIT_VALID(BIT_VALID),
    .P_READY(P_READY), .P_DATA(P_DATA), .P_VALID(P_VALID), .P_LAST(P_LAST),
    .FRAME_START(FRAME_START), .OVERRUN(OVERRUN), .BUSY(BUSY),
    .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit         in_frame;
  bit         hunt_q[$];
  bit         pay_q[$];
  int         nbytes;
  logic [7:0] e_data;
  bit         e_valid, e_last, e_start, e_ovr, e_busy;
  logic [7:0] e_cnt;

  // Observations of the DUT for directed expectations
  logic [7:0] xfer_q[$];
  bit         xlast_q[$];
  int         start_seen;
  int         gap_pct;

  function automatic logic [7:0] pack(input bit q[$]);
    logic [7:0] v = 8'h00;
    for (int i = 0; i < 8; i++) v = {v[6:0], q[i]};
    return v;
  endfunction

  function automatic logic [31:0] xfer_word();
    logic [31:0] w = 32'h0;
    for (int i = 0; i < xfer_q.size() && i < 4; i++) w = {w[23:0], xfer_q[i]};
    return w;
  endfunction

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    in_frame = 0; hunt_q.delete(); pay_q.delete(); nbytes = 0;
    e_data = 8'h00; e_valid = 0; e_last = 0; e_start = 0; e_ovr = 0;
    e_busy = 0; e_cnt = 8'd0;
  endtask

  task automatic model_step(input bit bv, input bit s, input bit r);
    bit         loaded = 0;
    bit         take = e_valid && r;
    bit         is_last;
    logic [7:0] b;
    e_start = 0;
    e_ovr   = 0;
    if (bv) begin
      if (!in_frame) begin
        hunt_q.push_back(s);
        if (hunt_q.size() > 8) void'(hunt_q.pop_front());
        if (hunt_q.size() == 8 && pack(hunt_q) == SYNC) begin
          in_frame = 1; nbytes = 0; pay_q.delete(); hunt_q.delete(); e_start = 1;
        end
      end else begin
        pay_q.push_back(s);
        if (pay_q.size() == 8) begin
          b = pack(pay_q);
          pay_q.delete();
          nbytes++;
          is_last = (nbytes == NB);
          if (!e_valid || r) begin
            e_data = b; e_last = is_last; loaded = 1;
            if (is_last) begin
              in_frame = 0; e_cnt = e_cnt + 8'd1; hunt_q.delete();
            end
          end else begin
            e_ovr = 1; in_frame = 0; hunt_q.delete();
          end
        end
      end
    end
    if (loaded) e_valid = 1;
    else if (take) e_valid = 0;
    e_busy = in_frame;
  endtask

  task automatic check_outputs();
    bit ok;
    n_checks++;
    ok = (P_VALID === e_valid) && (FRAME_START === e_start) && (OVERRUN === e_ovr) &&
         (BUSY === e_busy) && (FRAME_CNT === e_cnt) &&
         (!e_valid || (P_DATA === e_data && P_LAST === e_last));
    if (!ok) begin
      n_fail++;
      $display("FAIL cycle_compare t=%0t got data=%h v=%b last=%b fs=%b ov=%b busy=%b cnt=%0d expected data=%h v=%b last=%b fs=%b ov=%b busy=%b cnt=%0d",
               $time, P_DATA, P_VALID, P_LAST, FRAME_START, OVERRUN, BUSY, FRAME_CNT,
               e_data, e_valid, e_last, e_start, e_ovr, e_busy, e_cnt);
    end
    if (FRAME_START === 1'b1) start_seen++;
  endtask

  task automatic tick(input bit bv, input bit s, input bit r);
    @(negedge CLK);
    check_outputs();
    BIT_VALID = bv; S_IN = s; P_READY = r;
    if (P_VALID === 1'b1 && r) begin
      xfer_q.push_back(P_DATA);
      xlast_q.push_back(P_LAST);
    end
    @(posedge CLK);
    model_step(bv, s, r);
  endtask

  // mode: 0 ready high, 1 ready low, 2 random, 3 low except on the last bit
  function automatic bit pick_rdy(input int mode, input bit last);
    case (mode)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return 1'($urandom_range(0, 1));
      default: return last;
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] b, input int mode);
    for (int i = 7; i >= 0; i--) begin
      while (gap_pct != 0 && $urandom_range(0, 99) < gap_pct)
        tick(1'b0, 1'($urandom_range(0, 1)), pick_rdy(mode, 1'b0));
      tick(1'b1, b[i], pick_rdy(mode, i == 0));
    end
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, r);
  endtask

  task automatic do_reset(input string name);
    @(negedge CLK);
    RESET = 1'b0; BIT_VALID = 1'b0; P_READY = 1'b0;
    model_reset();
    #1;
    lit(name, {P_DATA, P_VALID, P_LAST, FRAME_START, OVERRUN, BUSY, FRAME_CNT}, 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    model_step(1'b0, S_IN, 1'b0);
  endtask

  task automatic clear_obs();
    xfer_q.delete(); xlast_q.delete();
  endtask

  initial begin
    int         s0;
    logic [7:0] sw;
    model_reset();
    gap_pct = 0;
    start_seen = 0;
    #2;
    do_reset("reset_values");

    // Basic frame, continuous bits, consumer always ready
    clear_obs();
    send_byte(SYNC, 0);
    #1 lit("t1_frame_start", {31'd0, FRAME_START}, 1);
    lit("t1_busy_on", {31'd0, BUSY}, 1);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    #1 lit("t1_last_byte", {P_DATA, P_VALID, P_LAST, BUSY}, {8'h44, 1'b1, 1'b1, 1'b0});
    lit("t1_frame_cnt", FRAME_CNT, 1);
    idle(3, 1'b1);
    lit("t1_xfer", xfer_word(), 32'h11223344);
    lit("t1_last_flags", {xlast_q.size() == 4, xlast_q[0], xlast_q[1], xlast_q[2], xlast_q[3]}, 5'b10001);
    lit("t1_start_count", start_seen, 1);

    // Sync preceded by an odd number of ones: no early match
    s0 = start_seen;
    send_byte(8'hFF, 0);
    tick(1'b1, 1'b1, 1'b1);
    send_byte(SYNC, 0);
    #1 lit("t2_start_on_final_bit", {31'd0, FRAME_START}, 1);
    lit("t2_no_early_start", start_seen - s0, 0);
    for (int i = 0; i < NB; i++) send_byte(8'($urandom), 0);
    idle(2, 1'b1);

    // Consumer stalled for the whole frame
    send_byte(SYNC, 1); send_byte(8'hA1, 1); send_byte(8'hB2, 1);
    #1 lit("t3_overrun", {OVERRUN, BUSY, P_VALID, P_DATA}, {1'b1, 1'b0, 1'b1, 8'hA1});
    lit("t3_cnt_held", FRAME_CNT, 2);
    idle(3, 1'b0);
    #1 lit("t3_data_stable", {P_VALID, P_DATA}, {1'b1, 8'hA1});
    idle(1, 1'b1);
    #1 lit("t3_drained", {31'd0, P_VALID}, 0);

    // Ready arrives exactly as byte 2 completes
    clear_obs();
    send_byte(SYNC, 0); send_byte(8'hC3, 1); send_byte(8'hD4, 3);
    #1 lit("t4_swap", {OVERRUN, P_VALID, P_DATA}, {1'b0, 1'b1, 8'hD4});
    send_byte(8'hE5, 0); send_byte(8'hF6, 0);
    idle(2, 1'b1);
    lit("t4_xfer", xfer_word(), 32'hC3D4E5F6);
    lit("t4_frame_cnt", FRAME_CNT, 3);

    // Sync code as payload, then a tail that would complete a sync with old bits
    clear_obs();
    s0 = start_seen;
    sw = SYNC;
    send_byte(SYNC, 0);
    for (int i = 0; i < NB; i++) send_byte(SYNC, 0);
    for (int i = 6; i >= 0; i--) tick(1'b1, sw[i], 1'b1);
    idle(2, 1'b1);
    lit("t5_single_start", start_seen - s0, 1);
    lit("t5_xfer", xfer_word(), 32'h5A5A5A5A);
    lit("t5_no_resync", {BUSY, FRAME_CNT}, {1'b0, 8'd4});

    // Reset in the middle of byte 3 with a byte pending
    do_reset("t6_pre_reset");
    send_byte(SYNC, 0); send_byte(8'h11, 0); send_byte(8'h22, 3);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0);
    do_reset("t6_mid_frame_reset");
    clear_obs();
    gap_pct = 20;
    send_byte(SYNC, 0);
    send_byte(8'h91, 0); send_byte(8'h92, 0); send_byte(8'h93, 0); send_byte(8'h94, 0);
    idle(3, 1'b1);
    lit("t6_clean_xfer", xfer_word(), 32'h91929394);
    lit("t6_frame_cnt", FRAME_CNT, 1);

    // Randomized traffic: gaps, random ready, frequent sync codes
    gap_pct = 25;
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 99) < 30) send_byte(SYNC, ($urandom_range(0, 3) == 0) ? 0 : 2);
      else send_byte(8'($urandom), ($urandom_range(0, 3) == 0) ? 0 : 2);
    end
    idle(3, 1'b1);

    // Frame counter wrap
    gap_pct = 0;
    do_reset("t8_reset");
    for (int f = 0; f < 255; f++) begin
      send_byte(SYNC, 0);
      for (int i = 0; i < NB; i++) send_byte(8'($urandom), 0);
    end
    idle(1, 1'b1);
    lit("t8_cnt_255", FRAME_CNT, 255);
    send_byte(SYNC, 0);
    for (int i = 0; i < NB; i++) send_byte(8'($urandom), 0);
    idle(1, 1'b1);
    lit("t8_cnt_wrap", FRAME_CNT, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
